// File: rtl/fpdiv_iter.sv
// Iterative FP16 (1/5/10, bias 15) divider: radix-2 restoring, one quotient bit per cycle, fixed 15-cycle latency.
// Define FPDIV_FLUSH_SUB_EN to flush subnormal inputs and results to signed zero.
module fpdiv_iter #(
    parameter int QBITS = 13
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        overflow,
    output logic        sub,
    output logic        divzero
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_FIN} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_SAT, SP_DIVZ, SP_ZERO} spec_t;

    state_t             r_state, w_state_nxt;
    spec_t              r_spec, w_spec;
    logic [15:0]        r_a, r_b;
    logic               r_sign;
    logic signed [6:0]  r_e;
    logic [10:0]        r_mb;
    logic [11:0]        r_rem;
    logic [QBITS-1:0]   r_q;
    logic [3:0]         r_cnt;
    logic               r_done;
    logic [15:0]        r_out;
    logic               r_ovf, r_sub, r_dz;

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign out      = r_out;
    assign overflow = r_ovf;
    assign sub      = r_sub;
    assign divzero  = r_dz;

`ifndef FPDIV_FLUSH_SUB_EN
    function automatic logic [3:0] lead_zeros(input logic [10:0] m);
        lead_zeros = 4'd0;
        for (int i = 0; i <= 10; i++) begin
            if (m[i]) lead_zeros = 4'(10 - i);
        end
    endfunction
`endif

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every combinational output is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_PREP;
            S_PREP:  w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == 4'(QBITS - 1)) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand unpack: hidden bit, effective exponent, subnormal normalization, special classes.
    logic [4:0]        w_fa, w_fb;
    logic [10:0]       w_ma, w_mb;
    logic signed [6:0] w_ea, w_eb, w_e_prep;
    logic              w_a_zero, w_b_zero;
`ifndef FPDIV_FLUSH_SUB_EN
    logic [3:0]        w_lza, w_lzb;
`endif

    always_comb begin
        w_fa = r_a[14:10];
        w_fb = r_b[14:10];
        w_ma = {(w_fa != 5'd0), r_a[9:0]};
        w_mb = {(w_fb != 5'd0), r_b[9:0]};
        w_ea = signed'({2'b00, (w_fa == 5'd0) ? 5'd1 : w_fa});
        w_eb = signed'({2'b00, (w_fb == 5'd0) ? 5'd1 : w_fb});
`ifdef FPDIV_FLUSH_SUB_EN
        w_a_zero = (w_fa == 5'd0);
        w_b_zero = (w_fb == 5'd0);
`else
        w_a_zero = (r_a[14:0] == 15'd0);
        w_b_zero = (r_b[14:0] == 15'd0);
        w_lza    = lead_zeros(w_ma);
        w_lzb    = lead_zeros(w_mb);
        w_ma     = w_ma << w_lza;
        w_mb     = w_mb << w_lzb;
        w_ea     = w_ea - signed'({3'b000, w_lza});
        w_eb     = w_eb - signed'({3'b000, w_lzb});
`endif
        w_e_prep = w_ea - w_eb + 7'sd15;
        if (w_fa == 5'h1F || w_fb == 5'h1F) w_spec = SP_SAT;
        else if (w_b_zero)                  w_spec = SP_DIVZ;
        else if (w_a_zero)                  w_spec = SP_ZERO;
        else                                w_spec = SP_NONE;
    end

    // One restoring step: remainder stays below 2*mb, so the shifted value fits 12 bits.
    logic        w_ge;
    logic [11:0] w_rem_next;

    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_rem_next = w_ge ? ((r_rem - {1'b0, r_mb}) << 1) : (r_rem << 1);
    end

    // Normalize, denormalize, round to nearest even, pack.
    logic [10:0]       w_mant;
    logic              w_guard, w_sticky, w_inc, w_sub_res, w_ovf_res, w_dz_res;
    logic signed [7:0] w_en;
    logic [6:0]        w_base;
    logic [16:0]       w_sum;
    logic [15:0]       w_res;
`ifdef FPDIV_FLUSH_SUB_EN
    logic              w_uflow;
`else
    logic [11:0]       w_x;
    logic [7:0]        w_sh;
    logic              w_lost;
`endif

    always_comb begin
        w_mant   = r_q[QBITS-1] ? r_q[QBITS-1 -: 11] : r_q[QBITS-2 -: 11];
        w_guard  = r_q[QBITS-1] ? r_q[QBITS-12] : r_q[QBITS-13];
        w_sticky = (r_rem != 12'd0) | (r_q[QBITS-1] & r_q[0]);
        w_en     = signed'({r_e[6], r_e}) - (r_q[QBITS-1] ? 8'sd0 : 8'sd1);
        w_base   = 7'd0;
`ifdef FPDIV_FLUSH_SUB_EN
        w_uflow  = (w_en <= 8'sd0);
        if (!w_uflow) w_base = w_en[6:0] - 7'd1;
`else
        w_x      = {w_mant, w_guard};
        w_sh     = 8'd0;
        w_lost   = 1'b0;
        if (w_en <= 8'sd0) begin
            w_sh = 8'(8'sd1 - w_en);
            if (w_sh >= 8'd12) begin
                w_lost = |w_x;
                w_x    = 12'd0;
            end else begin
                w_lost = |(w_x & ((12'd1 << w_sh[3:0]) - 12'd1));
                w_x    = w_x >> w_sh[3:0];
            end
            w_mant   = w_x[11:1];
            w_guard  = w_x[0];
            w_sticky = w_sticky | w_lost;
        end else begin
            w_base = w_en[6:0] - 7'd1;
        end
`endif
        w_inc = w_guard & (w_sticky | w_mant[0]);
        // Adding the mantissa with its hidden bit onto (e-1)<<10 lets a rounding carry bump the exponent.
        w_sum = {w_base, 10'b0} + {6'b0, w_mant} + {16'b0, w_inc};
        w_res     = {r_sign, w_sum[14:0]};
        w_ovf_res = 1'b0;
        w_dz_res  = 1'b0;
        if (w_sum >= 17'h07C00) begin
            w_res     = {r_sign, 15'h7FFF};
            w_ovf_res = 1'b1;
        end
`ifdef FPDIV_FLUSH_SUB_EN
        if (w_uflow) w_res = {r_sign, 15'h0000};
`endif
        case (r_spec)
            SP_SAT:  begin w_res = {r_sign, 15'h7FFF}; w_ovf_res = 1'b1; end
            SP_DIVZ: begin w_res = {r_sign, 15'h7FFF}; w_ovf_res = 1'b1; w_dz_res = 1'b1; end
            SP_ZERO: begin w_res = {r_sign, 15'h0000}; w_ovf_res = 1'b0; end
            default: ;
        endcase
        w_sub_res = (w_res[14:10] == 5'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a    <= 16'd0;
            r_b    <= 16'd0;
            r_sign <= 1'b0;
            r_e    <= 7'sd0;
            r_mb   <= 11'd0;
            r_rem  <= 12'd0;
            r_q    <= '0;
            r_cnt  <= 4'd0;
            r_spec <= SP_NONE;
            r_done <= 1'b0;
            r_out  <= 16'd0;
            r_ovf  <= 1'b0;
            r_sub  <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_PREP: begin
                    r_sign <= r_a[15] ^ r_b[15];
                    r_e    <= w_e_prep;
                    r_mb   <= w_mb;
                    r_rem  <= {1'b0, w_ma};
                    r_q    <= '0;
                    r_cnt  <= 4'd0;
                    r_spec <= w_spec;
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_FIN: begin
                    r_out  <= w_res;
                    r_ovf  <= w_ovf_res;
                    r_sub  <= w_sub_res;
                    r_dz   <= w_dz_res;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv_iter.sv
// Self-checking bench for fpdiv_iter: directed cases, protocol checks and random operands
// against an exact rational-arithmetic FP16 division model.
module tb_fpdiv_iter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        busy, done, overflow, sub, divzero;
    logic [15:0] out;

    int n_tests = 0;
    int n_fail  = 0;

    fpdiv_iter #(.QBITS(13)) dut (
        .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .out(out),
        .overflow(overflow), .sub(sub), .divzero(divzero)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact quotient rounded to FP16 with round-to-nearest-even; result packed as {ovf, sub, dz, out}.
    function automatic logic [18:0] ref_div(input logic [15:0] x, input logic [15:0] y);
        logic   s;
        int     fx, fy, d, p, er, sh, field;
        longint nx, ny, num, qq, rr, sig, lowmask;
        bit     g, st;
        s  = x[15] ^ y[15];
        fx = int'(x[14:10]);
        fy = int'(y[14:10]);
        nx = longint'(x[9:0]) + ((fx != 0) ? 64'sd1024 : 64'sd0);
        ny = longint'(y[9:0]) + ((fy != 0) ? 64'sd1024 : 64'sd0);
`ifdef FPDIV_FLUSH_SUB_EN
        if (fx == 0) nx = 0;
        if (fy == 0) ny = 0;
`endif
        if (fx == 31 || fy == 31) return {3'b100, s, 15'h7FFF};
        if (ny == 0)              return {3'b101, s, 15'h7FFF};
        if (nx == 0)              return {3'b010, s, 15'h0000};
        d   = ((fx == 0) ? 1 : fx) - ((fy == 0) ? 1 : fy);
        num = nx << 40;
        qq  = num / ny;
        rr  = num % ny;
        p   = 0;
        for (int i = 0; i < 63; i++) if (qq[i]) p = i;
        er = p + d - 40;
`ifdef FPDIV_FLUSH_SUB_EN
        if (er < -14) return {3'b010, s, 15'h0000};
`endif
        if (er < -14) er = -14;
        sh      = er - (d - 40) - 10;
        sig     = qq >> sh;
        g       = qq[sh-1];
        lowmask = (64'sd1 << (sh - 1)) - 1;
        st      = ((qq & lowmask) != 0) || (rr != 0);
        if (g && (st || sig[0])) sig++;
        if (sig == 2048) begin
            sig = 1024;
            er++;
        end
        field = (sig >= 1024) ? er + 15 : 0;
        if (field >= 31) return {3'b100, s, 15'h7FFF};
        return {1'b0, (field == 0), 1'b0, s, 5'(field), 10'(sig)};
    endfunction

    // Issue one operation and check latency, busy span, result and flags.
    // now=1 raises start immediately (used from the done-cycle sample point).
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                          input logic [18:0] exp, input string tag, input bit now);
        int lat;
        int busy_cnt;
        if (!now) @(negedge CLK);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 15);
        check({tag, ".busy_cycles"}, busy_cnt, 15);
        check({tag, ".busy_at_done"}, busy, 0);
        check({tag, ".out"}, out, exp[15:0]);
        check({tag, ".overflow"}, overflow, exp[18]);
        check({tag, ".sub"}, sub, exp[17]);
        check({tag, ".divzero"}, divzero, exp[16]);
    endtask

    initial begin
        logic [15:0] ra, rb, held;
        int n_done;

        repeat (3) @(posedge CLK);
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.out", out, 0);
        check("reset.flags", {overflow, sub, divzero}, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op(16'h3C00, 16'h3C00, {3'b000, 16'h3C00}, "one_by_one", 1'b0);
        held = out;
        @(posedge CLK); #1;
        check("done_one_cycle", done, 0);
        check("out_held", out, held);

        run_op(16'h3C00, 16'h4200, {3'b000, 16'h3555}, "one_third", 1'b0);
        run_op(16'h4600, 16'hC000, {3'b000, 16'hC200}, "neg_quot", 1'b0);
        run_op(16'h3C00, 16'h0000, {3'b101, 16'h7FFF}, "div_zero", 1'b0);
        run_op(16'h7BFF, 16'h1400, {3'b100, 16'h7FFF}, "exp_ovf", 1'b0);
        run_op(16'h3C00, 16'h7C00, {3'b100, 16'h7FFF}, "b_inf", 1'b0);
        run_op(16'h0000, 16'h0000, {3'b101, 16'h7FFF}, "zero_zero", 1'b0);
        run_op(16'h8000, 16'h3C00, {3'b010, 16'h8000}, "neg_zero", 1'b0);
        run_op(16'h0001, 16'h4000, {3'b010, 16'h0000}, "tie_to_zero", 1'b0);
`ifdef FPDIV_FLUSH_SUB_EN
        run_op(16'h0400, 16'h4000, {3'b010, 16'h0000}, "to_subnormal", 1'b0);
        run_op(16'h0001, 16'h0001, {3'b101, 16'h7FFF}, "sub_by_sub", 1'b0);
        run_op(16'h0003, 16'h4000, {3'b010, 16'h0000}, "sub_tie_even", 1'b0);
`else
        run_op(16'h0400, 16'h4000, {3'b010, 16'h0200}, "to_subnormal", 1'b0);
        run_op(16'h0001, 16'h0001, {3'b000, 16'h3C00}, "sub_by_sub", 1'b0);
        run_op(16'h0003, 16'h4000, {3'b010, 16'h0002}, "sub_tie_even", 1'b0);
`endif
        // start raised in the done cycle of the previous operation
        run_op(16'h4600, 16'hC000, {3'b000, 16'hC200}, "done_cycle_start", 1'b1);

        // second start 5 cycles in must be ignored, operands not re-latched
        @(negedge CLK);
        a = 16'h3C00;
        b = 16'h4200;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        a = 16'h4600;
        b = 16'hC000;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n_done = 0;
        held = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done) begin
                n_done++;
                held = out;
            end
        end
        check("ignored_start.dones", n_done, 1);
        check("ignored_start.out", held, 16'h3555);

        // synchronous reset in the middle of the iterate phase
        @(negedge CLK);
        a = 16'h4600;
        b = 16'hC000;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.out", out, 0);
        check("abort.flags", {overflow, sub, divzero}, 0);
        @(negedge CLK);
        RST = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK); #1;
            if (done) n_done++;
        end
        check("abort.no_done", n_done, 0);
        run_op(16'h3C00, 16'h4200, {3'b000, 16'h3555}, "after_abort", 1'b0);

        // random operands, with subnormal and zero fields injected often
        for (int t = 0; t < 200; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra[14:10] = 5'd0;
            if ($urandom_range(0, 3) == 0) rb[14:10] = 5'd0;
            if ($urandom_range(0, 1) == 0) ra[14:10] = 5'($urandom_range(8, 22));
            if ($urandom_range(0, 1) == 0) rb[14:10] = 5'($urandom_range(8, 22));
            run_op(ra, rb, ref_div(ra, rb), "random", t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpdiv_iter.md
Name: fpdiv_iter

Overview:
- Iterative half-precision (1/5/10, bias 15) floating-point divider, out = a / b. It is the inverse-direction companion to the pipelined FP16 multiplier.
- Handshake interface: start/busy/done. One operation in flight at a time.
- Uses a radix-2 restoring divider, one quotient bit per cycle, then normalize, round and pack.
- Output flag semantics match the multiplier (overflow/sub), so downstream consumers handle both blocks identically.

Parameters:
- QBITS, 13, quotient bits generated in the iterate phase; fixed at 13 for FP16, exposed for bench visibility only.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- start  input  1  operation request; sampled when not busy
- a  input  16  dividend, FP16
- b  input  16  divisor, FP16
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; out/flags valid
- out  output  16  quotient, FP16, held until next done
- overflow  output  1  result exponent field saturated to 31
- sub  output  1  result exponent field is 0
- divzero  output  1  divisor magnitude is zero

Behaviour:
- Reset (RST=1 at a CLK edge): state=IDLE; busy, done, out, overflow, sub, divzero all 0; internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE -> PREP -> DIV (13 cycles) -> FIN -> IDLE.
  - Start sampled at edge k with state IDLE: a and b are latched.
  - busy=1 after edges k..k+14.
  - done=1 and busy=0 for exactly one cycle after edge k+15. Latency is fixed at 15 cycles for all operands, including special cases.
- start while busy is ignored; inputs are not re-latched.
- start in the done cycle is accepted (state is already IDLE).
- PREP:
  - sign = a[15]^b[15].
  - Hidden bit = (exp field != 0). Effective exponent = max(field, 1).
  - Subnormal operands are normalized with a priority encoder (leading-one position): mantissa shifted left until bit10=1, exponent decremented by the same count.
  - Working exponent e = ea - eb + 15, 7-bit signed.
  - Special-case flags are registered here.
- DIV: remainder R (12 bits) is initialized to ma. Each cycle: if R >= mb then q = {q,1}, R = (R-mb)<<1; else q = {q,0}, R = R<<1. Final sticky = (R != 0).
- FIN:
  - Normalize: if q[12], mant = q[12:2], guard = q[1], sticky |= q[0]. Else mant = q[11:1], guard = q[0], e = e-1.
  - If e <= 0: right-shift {mant, guard} by 1-e, ORing all shifted-out bits into sticky; exp field = 0. A shift of 12 or more gives mant = 0.
  - Round to nearest even: increment if guard && (sticky || mant[0]). A carry out of mant increments e; a subnormal that rounds up to bit10 becomes exp field 1.
  - If e >= 31: out = {sign, 5'h1F, 10'h3FF}, overflow=1.
- Special cases, taking priority in this order:
  1. a or b exp field = 31 -> {sign, 1F, 3FF}, overflow=1.
  2. b magnitude zero -> {sign, 1F, 3FF}, overflow=1, divzero=1.
  3. a magnitude zero -> {sign, 15'b0}, sub=1.
- sub = (out exp field == 0). overflow, sub and divzero update only at the done edge.

Optional Feature:
- FPDIV_FLUSH_SUB_EN:
  - Defined: subnormal inputs are treated as signed zero. Any result with e <= 0 after normalization becomes {sign, 15'b0} with sub=1. The PREP priority encoder and the FIN right shifter are omitted.
  - Undefined: gradual underflow as specified above.
  - Latency is unchanged either way.

Test Plan:
- a=0x3C00, b=0x3C00, start at edge k -> done at edge k+15, out=0x3C00, all flags 0; busy high 15 cycles.
- a=0x3C00, b=0x4200 (1/3) -> out=0x3555. Then a=0x4600, b=0xC000 -> out=0xC200.
- a=0x3C00, b=0x0000 -> out=0x7FFF, overflow=1, divzero=1. Then a=0x7BFF, b=0x1400 -> out=0x7FFF, overflow=1, divzero=0.
- a=0x0400, b=0x4000 -> out=0x0200, sub=1; with FPDIV_FLUSH_SUB_EN -> out=0x0000, sub=1. Also a=0x0001, b=0x0001 (subnormal normalization) -> out=0x3C00.
- Second start pulsed 5 cycles after first -> ignored, exactly one done. start held in the done cycle -> next done 15 cycles later.
- RST=1 at iteration 7 -> next cycle busy=0, done=0, out=0; no done pulse follows. A new start then completes normally.
